// File: rtl/cursor_step_generator.sv
// Direction switch conditioner: 2-FF sync, per-bit debounce, opposing-pair cancel,
// and auto-repeating one-cycle step pulses that accelerate after ACCEL_STEPS repeats.
//   state  | meaning
//   IDLE   | no effective direction held, timer cleared
//   DELAY  | first step issued, waiting FIRST_DELAY for the first auto-repeat
//   REPEAT | auto-repeating at REPEAT_SLOW, then REPEAT_FAST once accelerated
module cursor_step_generator #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIRST_DELAY     = 6250000,
    parameter int REPEAT_SLOW     = 625000,
    parameter int REPEAT_FAST     = 125000,
    parameter int ACCEL_STEPS     = 32,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_up_raw,
    input  logic       sw_down_raw,
    input  logic       sw_left_raw,
    input  logic       sw_right_raw,
    output logic       step_up,
    output logic       step_down,
    output logic       step_left,
    output logic       step_right,
    output logic [3:0] held
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_M1  = CNT_W'(FIRST_DELAY - 1);
    localparam logic [CNT_W-1:0] SLOW_M1   = CNT_W'(REPEAT_SLOW - 1);
    localparam logic [CNT_W-1:0] FAST_M1   = CNT_W'(REPEAT_FAST - 1);
    localparam logic [CNT_W-1:0] ACCEL_MAX = CNT_W'(ACCEL_STEPS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] deb_cnt [4];
    logic [3:0]       eff;
    logic [3:0]       eff_prev;
    logic [3:0]       newly;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic [CNT_W-1:0] accel_q;
    logic [CNT_W-1:0] accel_d;
    logic [CNT_W-1:0] accel_inc;
    logic [3:0]       step_q;
    logic [3:0]       step_d;

    // Bit order everywhere is {up, down, left, right}.
    assign raw = {sw_up_raw, sw_down_raw, sw_left_raw, sw_right_raw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                deb_cnt[i] <= '0;
                held[i]    <= 1'b0;
            end else if (sync2[i] == held[i]) begin
                deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
                deb_cnt[i] <= '0;
                held[i]    <= ~held[i];
            end else begin
                deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    // Opposing directions held together cancel each other out.
    assign eff = {held[3] & ~held[2], held[2] & ~held[3],
                  held[1] & ~held[0], held[0] & ~held[1]};
    assign newly = eff & ~eff_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eff_prev <= '0;
            state_q  <= IDLE;
            timer_q  <= '0;
            accel_q  <= '0;
            step_q   <= '0;
        end else begin
            eff_prev <= eff;
            state_q  <= state_d;
            timer_q  <= timer_d;
            accel_q  <= accel_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        accel_d   = accel_q;
        step_d    = '0;
        accel_inc = (accel_q >= ACCEL_MAX) ? accel_q : accel_q + 1'b1;

        if (eff == 4'b0000) begin
            state_d = IDLE;
            timer_d = '0;
        end else if (newly != 4'b0000 || state_q == IDLE) begin
            // A newly effective direction restarts timing; only it is pulsed.
            step_d  = newly;
            timer_d = FIRST_M1;
            accel_d = '0;
            state_d = DELAY;
        end else begin
            case (state_q)
                DELAY: begin
                    if (timer_q == '0) begin
                        step_d  = eff;
                        timer_d = SLOW_M1;
                        accel_d = CNT_W'(1);
                        state_d = REPEAT;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                REPEAT: begin
                    if (timer_q == '0) begin
                        step_d  = eff;
                        accel_d = accel_inc;
                        timer_d = (accel_inc >= ACCEL_MAX) ? FAST_M1 : SLOW_M1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign {step_up, step_down, step_left, step_right} = step_q;

endmodule

// File: tb/tb_cursor_step_generator.sv
// Bench for cursor_step_generator: directed scenarios plus random switch activity,
// checked every cycle against a pulse-schedule model of the step generator.
module tb_cursor_step_generator;

    localparam int DEB = 4;
    localparam int FD  = 20;
    localparam int RS  = 8;
    localparam int RF  = 3;
    localparam int AS  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_up_raw, sw_down_raw, sw_left_raw, sw_right_raw;
    logic       step_up, step_down, step_left, step_right;
    logic [3:0] held;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit started = 1'b0;

    cursor_step_generator #(
        .DEBOUNCE_CYCLES(DEB),
        .FIRST_DELAY(FD),
        .REPEAT_SLOW(RS),
        .REPEAT_FAST(RF),
        .ACCEL_STEPS(AS),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_up_raw(sw_up_raw),
        .sw_down_raw(sw_down_raw),
        .sw_left_raw(sw_left_raw),
        .sw_right_raw(sw_right_raw),
        .step_up(step_up),
        .step_down(step_down),
        .step_left(step_left),
        .step_right(step_right),
        .held(held)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] m_s1 = '0, m_s2 = '0, m_held = '0, m_eff_prev = '0;
    logic [3:0] m_eff, m_newly, exp_step = '0;
    logic [3:0] hist[$];
    int anchor = -1;
    bit differ;
    int m_up_t[$];

    function automatic logic [3:0] cancel(input logic [3:0] h);
        return {h[3] & ~h[2], h[2] & ~h[3], h[1] & ~h[0], h[0] & ~h[1]};
    endfunction

    // Pulse offsets after a fresh press: FD, then slow intervals, then fast forever.
    function automatic bit is_pulse(input int k);
        int ns;
        int k2;
        ns = (AS > 1) ? AS - 1 : 1;
        if (k == FD) return 1'b1;
        if (k < FD) return 1'b0;
        k2 = k - FD;
        if (k2 <= ns * RS) return (k2 % RS) == 0;
        return ((k2 - ns * RS) % RF) == 0;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_held = '0; m_eff_prev = '0;
            exp_step = '0; anchor = -1;
            hist.delete();
        end else begin
            m_eff   = cancel(m_held);
            m_newly = m_eff & ~m_eff_prev;
            exp_step = '0;
            if (m_eff == 4'b0000) begin
                anchor = -1;
            end else if (m_newly != 4'b0000) begin
                exp_step = m_newly;
                anchor = cyc;
            end else if (anchor >= 0 && is_pulse(cyc - anchor)) begin
                exp_step = m_eff;
            end
            m_eff_prev = m_eff;
            // A level is accepted once DEB consecutive synced samples disagree with it.
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            if (hist.size() == DEB) begin
                for (int i = 0; i < 4; i++) begin
                    differ = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (hist[k][i] == m_held[i]) differ = 1'b0;
                    if (differ) m_held[i] = ~m_held[i];
                end
            end
            m_s2 = m_s1;
            m_s1 = {sw_up_raw, sw_down_raw, sw_left_raw, sw_right_raw};
        end
        if (exp_step[3]) m_up_t.push_back(cyc);
    end

    // ---------------- checking ----------------
    int up_t[$], dn_t[$], lf_t[$], rt_t[$], lrise_t[$];
    logic held_l_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("step", {step_up, step_down, step_left, step_right}, exp_step);
            chk("held", held, m_held);
            if (step_up)    up_t.push_back(cyc);
            if (step_down)  dn_t.push_back(cyc);
            if (step_left)  lf_t.push_back(cyc);
            if (step_right) rt_t.push_back(cyc);
            if (held[1] && !held_l_prev) lrise_t.push_back(cyc);
            held_l_prev = held[1];
        end
    end

    function automatic int nth_after(input int q[$], input int t, input int n);
        int seen;
        seen = 0;
        foreach (q[k]) begin
            if (q[k] >= t) begin
                if (seen == n) return q[k];
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int c;
        c = 0;
        foreach (q[k]) if (q[k] >= lo && q[k] <= hi) c++;
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [3:0] v);
        {sw_up_raw, sw_down_raw, sw_left_raw, sw_right_raw} = v;
    endtask

    // ---------------- stimulus ----------------
    int c0, r, rl, p;
    int hold_off[5] = '{7, 27, 35, 38, 41};
    int diag_off[4] = '{7, 27, 35, 38};

    initial begin
        rst_n = 1'b0;
        set_raw(4'b0000);
        @(negedge clk);
        started = 1'b1;
        chk("reset_step", {step_up, step_down, step_left, step_right}, 4'b0000);
        chk("reset_held", held, 4'b0000);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // clean hold of up
        c0 = cyc;
        set_raw(4'b1000);
        tick(60);
        for (int j = 0; j < 5; j++) begin
            chk("hold_up_time", nth_after(up_t, c0, j), c0 + hold_off[j]);
            chk("model_up_time", nth_after(m_up_t, c0, j), c0 + hold_off[j]);
        end
        chk("hold_no_other", count_in(dn_t, c0, cyc) + count_in(lf_t, c0, cyc)
            + count_in(rt_t, c0, cyc), 0);
        set_raw(4'b0000);
        tick(15);

        // bouncing left, then held high
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            sw_left_raw = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick(2);
        end
        sw_left_raw = 1'b1;
        r = cyc;
        tick(30);
        chk("bounce_held_rise", nth_after(lrise_t, c0, 0), r + 6);
        chk("bounce_first_step", nth_after(lf_t, c0, 0), r + 7);
        set_raw(4'b0000);
        tick(15);

        // opposing up+down, then release down
        c0 = cyc;
        set_raw(4'b1100);
        tick(30);
        chk("opp_held", held, 4'b1100);
        chk("opp_no_pulse", count_in(up_t, c0, cyc) + count_in(dn_t, c0, cyc), 0);
        set_raw(4'b1000);
        r = cyc;
        tick(35);
        chk("opp_up_first", nth_after(up_t, r, 0), r + 7);
        chk("opp_up_second", nth_after(up_t, r, 1), r + 27);
        set_raw(4'b0000);
        tick(15);

        // diagonal: up, then right added 10 cycles after first step_up
        c0 = cyc;
        set_raw(4'b1000);
        tick(17);
        set_raw(4'b1001);
        r = cyc;
        tick(60);
        for (int j = 0; j < 4; j++)
            chk("diag_right_time", nth_after(rt_t, r, j), r + diag_off[j]);
        chk("diag_up_restart", nth_after(up_t, r, 0), r + 27);

        // release both, then press right again
        set_raw(4'b0000);
        rl = cyc;
        tick(15);
        set_raw(4'b0001);
        p = cyc;
        tick(50);
        chk("release_quiet", count_in(rt_t, rl + 7, p) + count_in(up_t, rl + 7, p), 0);
        for (int j = 0; j < 3; j++)
            chk("repress_time", nth_after(rt_t, p, j), p + hold_off[j]);
        set_raw(4'b0000);
        tick(15);

        // reset during REPEAT with the switch still held
        set_raw(4'b1000);
        tick(40);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_step", {step_up, step_down, step_left, step_right}, 4'b0000);
        chk("midrst_held", held, 4'b0000);
        rst_n = 1'b1;
        r = cyc;
        tick(40);
        chk("midrst_next", nth_after(up_t, r, 0), r + 7);
        chk("midrst_repeat", nth_after(up_t, r, 1), r + 27);
        set_raw(4'b0000);
        tick(15);

        // random switch activity with occasional resets
        for (int s = 0; s < 150; s++) begin
            set_raw(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick($urandom_range(1, 40));
        end
        set_raw(4'b0000);
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
